// File: rtl/stream_qos_scheduler.sv
// stream_qos_scheduler
// Packet-level scheduler that shares one AXI-Stream-style output among
// STREAM_COUNT input streams. Each packet is picked by QoS priority, ties go
// round-robin, and streams that keep losing are promoted by an age counter.
// A granted stream owns the output until its last beat has been accepted.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   s_data_i   per-stream beat data (unpacked array)
//   s_qos_i    per-stream QoS, only looked at while arbitrating
//   s_last_i   per-stream last-beat flag
//   s_valid_i  per-stream beat valid
//   s_ready_o  per-stream beat accepted
//   m_data_o   data of the granted stream
//   m_qos_o    raw QoS captured when the grant was made
//   m_id_o     index of the granted stream
//   m_last_o   last flag of the granted stream
//   m_valid_o  output beat valid
//   m_ready_i  downstream ready
module stream_qos_scheduler #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int AGE_WIDTH    = 4,
  parameter int AGE_LIMIT    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT],
  input  logic [T_QOS__WIDTH-1:0] s_qos_i  [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int KEY_W = T_QOS__WIDTH + 1;
  localparam logic [AGE_WIDTH-1:0] AGE_LIM = AGE_WIDTH'(AGE_LIMIT);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [T_ID___WIDTH-1:0] gnt_id;
  logic [T_QOS__WIDTH-1:0] gnt_qos;
  logic [T_ID___WIDTH-1:0] rr_ptr;
  logic [AGE_WIDTH-1:0]    age [STREAM_COUNT];
  logic [T_ID___WIDTH-1:0] arb_id;
  logic                    arb_fire;

  assign arb_fire = (state == IDLE) && (|s_valid_i);

  // Arbitration: walk the streams starting at rr_ptr and keep the first one
  // with the strictly highest {starved, qos} key, which gives round-robin
  // tie-breaking for free.
  always_comb begin
    logic [KEY_W-1:0]        best_key;
    logic [KEY_W-1:0]        key;
    logic                    found;
    logic [T_ID___WIDTH-1:0] idx_w;
    int                      idx;
    best_key = '0;
    key      = '0;
    found    = 1'b0;
    idx_w    = '0;
    idx      = 0;
    arb_id   = '0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= STREAM_COUNT) begin
        idx = idx - STREAM_COUNT;
      end
      idx_w = T_ID___WIDTH'(idx);
      if (s_valid_i[idx_w]) begin
        key = {age[idx_w] >= AGE_LIM, s_qos_i[idx_w]};
        if (!found || key > best_key) begin
          found    = 1'b1;
          best_key = key;
          arb_id   = idx_w;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: leave GRANT only once the last beat is handed over
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|s_valid_i) state_next = GRANT;
      GRANT:   if (m_valid_o && m_ready_i && m_last_o) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the granted stream is passed straight through, so a source
  // bubble simply shows up as m_valid_o low while the grant is held.
  always_comb begin
    m_data_o  = '0;
    m_last_o  = 1'b0;
    m_valid_o = 1'b0;
    s_ready_o = '0;
    if (state == GRANT) begin
      m_data_o          = s_data_i[gnt_id];
      m_last_o          = s_last_i[gnt_id];
      m_valid_o         = s_valid_i[gnt_id];
      s_ready_o[gnt_id] = m_ready_i;
    end
  end

  assign m_id_o  = gnt_id;
  assign m_qos_o = gnt_qos;

  // Grant registers: captured once per packet, held through GRANT and IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_id  <= '0;
      gnt_qos <= '0;
      rr_ptr  <= '0;
    end else if (arb_fire) begin
      gnt_id  <= arb_id;
      gnt_qos <= s_qos_i[arb_id];
      rr_ptr  <= (arb_id == LAST_ID) ? '0 : arb_id + 1'b1;
    end
  end

  // Age counters: the winner restarts at zero, valid losers count up and
  // saturate, idle streams keep whatever age they had.
  for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_age
    always_ff @(posedge clk) begin
      if (rst) begin
        age[g] <= '0;
      end else if (arb_fire) begin
        if (arb_id == T_ID___WIDTH'(g)) begin
          age[g] <= '0;
        end else if (s_valid_i[g] && age[g] != AGE_MAX) begin
          age[g] <= age[g] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_qos_scheduler.sv
// tb_stream_qos_scheduler
// Drives packet sources into stream_qos_scheduler and compares every output
// on every cycle against a behavioural scheduler model, with directed
// scenarios whose grant order and timing are pinned by literal values.
module tb_stream_qos_scheduler;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int IW = 1;
  localparam int AW = 4;
  localparam int AL = 3;
  localparam int AGE_SAT = (1 << AW) - 1;
  localparam int VW = 2 + DW + IW + QW + N;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data [N];
  logic [QW-1:0] s_qos  [N];
  logic [N-1:0]  s_last;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_ready;
  logic [DW-1:0] m_data;
  logic [QW-1:0] m_qos;
  logic [IW-1:0] m_id;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;

  always #5 clk = ~clk;

  stream_qos_scheduler #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N),
    .T_ID___WIDTH(IW), .AGE_WIDTH(AW), .AGE_LIMIT(AL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data), .s_qos_i(s_qos), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_qos_o(m_qos), .m_id_o(m_id),
    .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // packet sources
  int src_rem[N];
  int src_beat[N];
  int src_pkts[N];
  int src_len[N];
  int src_prob[N];
  int src_qos[N];
  int ready_prob;
  bit rst_req;

  // behavioural scheduler model
  bit       known;
  int       owner;
  int       age[N];
  int       rr;
  int       last_id;
  int       last_qos;
  bit [N-1:0] exp_ready;
  int       cyc;

  int glog_id[$];
  int glog_qos[$];
  int glog_cyc[$];
  int dlog_valid[$];
  int dlog_last[$];
  int dlog_data[$];
  int dlog_id[$];
  int dlog_qos[$];
  int dlog_ready[$];

  function automatic int g_id(int k);
    return (glog_id.size() > k) ? glog_id[k] : -1;
  endfunction

  function automatic int g_qos(int k);
    return (glog_qos.size() > k) ? glog_qos[k] : -1;
  endfunction

  function automatic int g_cyc(int k);
    return (glog_cyc.size() > k) ? glog_cyc[k] : -1;
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of source/sink behaviour just after the rising edge
  task automatic applyStimulus();
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      if (src_rem[i] == 0 && src_pkts[i] > 0) begin
        src_rem[i] = (src_len[i] > 0) ? src_len[i] : int'($urandom_range(4, 1));
        src_pkts[i]--;
      end
      s_valid[i] = (src_rem[i] > 0) && ($urandom_range(99) < src_prob[i]);
      s_last[i]  = (src_rem[i] == 1);
      s_data[i]  = DW'(i * 128 + src_beat[i] % 128);
      if (src_qos[i] >= 0) s_qos[i] = QW'(src_qos[i]);
      else if ($urandom_range(7) == 0) s_qos[i] = QW'($urandom_range(15));
    end
    m_ready = ($urandom_range(99) < ready_prob);
  endtask

  // Compare all outputs against what the model says they must be
  task automatic checkOutput();
    logic [VW-1:0] act;
    logic [VW-1:0] exp;
    int ev;
    int el;
    int ed;
    exp_ready = '0;
    if (!known) return;
    ev = 0; el = 0; ed = 0;
    if (owner >= 0) begin
      ev = int'(s_valid[owner]);
      el = int'(s_last[owner]);
      ed = int'(s_data[owner]);
      exp_ready[owner] = m_ready;
    end
    act = {m_valid, m_last, m_data, m_id, m_qos, s_ready};
    exp = {1'(ev), 1'(el), DW'(ed), IW'(last_id), QW'(last_qos), exp_ready};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL cycle%0d outputs {valid,last,data,id,qos,ready}: got %h expected %h",
               cyc, act, exp);
    end
    dlog_valid.push_back(int'(m_valid));
    dlog_last.push_back(int'(m_last));
    dlog_data.push_back(int'(m_data));
    dlog_id.push_back(int'(m_id));
    dlog_qos.push_back(int'(m_qos));
    dlog_ready.push_back(int'(s_ready));
  endtask

  // Advance sources and the model to the state after the coming edge
  task automatic model_step();
    int key[N];
    int maxkey;
    int g;
    int idx;
    for (int i = 0; i < N; i++) begin
      if (s_valid[i] && exp_ready[i]) begin
        src_beat[i]++;
        src_rem[i]--;
      end
    end
    if (rst) begin
      known = 1'b1;
      owner = -1;
      rr = 0;
      last_id = 0;
      last_qos = 0;
      for (int i = 0; i < N; i++) age[i] = 0;
    end else if (known) begin
      if (owner < 0) begin
        if (s_valid != '0) begin
          maxkey = -1;
          g = -1;
          for (int i = 0; i < N; i++) begin
            key[i] = ((age[i] >= AL) ? (1 << QW) : 0) + int'(s_qos[i]);
            if (s_valid[i] && key[i] > maxkey) maxkey = key[i];
          end
          for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (g < 0 && s_valid[idx] && key[idx] == maxkey) g = idx;
          end
          for (int i = 0; i < N; i++) begin
            if (i == g) age[i] = 0;
            else if (s_valid[i] && age[i] < AGE_SAT) age[i] = age[i] + 1;
          end
          rr = (g + 1) % N;
          owner = g;
          last_id = g;
          last_qos = int'(s_qos[g]);
          glog_id.push_back(g);
          glog_qos.push_back(last_qos);
          glog_cyc.push_back(cyc);
        end
      end else if (s_valid[owner] && m_ready && s_last[owner]) begin
        owner = -1;
      end
    end
    cyc++;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    model_step();
  endtask

  task automatic set_src(input int i, input int pkts, input int len, input int qos, input int prob);
    src_pkts[i] = pkts;
    src_len[i]  = len;
    src_qos[i]  = qos;
    src_prob[i] = prob;
  endtask

  // Silence all sources, reset for two cycles, clear the logs
  task automatic reset_phase();
    for (int i = 0; i < N; i++) begin
      src_rem[i] = 0;
      src_beat[i] = 0;
      set_src(i, 0, 1, 0, 100);
    end
    ready_prob = 100;
    rst_req = 1'b1;
    run_cycle();
    run_cycle();
    rst_req = 1'b0;
    for (int i = 0; i < N; i++) src_beat[i] = 0;
    cyc = 0;
    glog_id.delete(); glog_qos.delete(); glog_cyc.delete();
    dlog_valid.delete(); dlog_last.delete(); dlog_data.delete();
    dlog_id.delete(); dlog_qos.delete(); dlog_ready.delete();
  endtask

  initial begin
    int exp_ids[8];
    int exp_qs[8];
    rst = 1'b1;
    rst_req = 1'b1;
    m_ready = 1'b0;
    s_valid = '0;
    s_last = '0;
    for (int i = 0; i < N; i++) begin
      s_data[i] = '0;
      s_qos[i] = '0;
      age[i] = 0;
    end
    known = 1'b0;
    owner = -1;
    rr = 0;
    last_id = 0;
    last_qos = 0;
    cyc = 0;

    // single source, 4 beats, qos 5
    reset_phase();
    set_src(0, 1, 4, 5, 100);
    repeat (8) run_cycle();
    for (int c = 0; c < 6; c++) begin
      check_val($sformatf("single.valid[%0d]", c), dlog_valid[c], (c >= 1 && c <= 4) ? 1 : 0);
      check_val($sformatf("single.last[%0d]", c), dlog_last[c], (c == 4) ? 1 : 0);
      check_val($sformatf("single.data[%0d]", c), dlog_data[c], (c >= 1 && c <= 4) ? c - 1 : 0);
      check_val($sformatf("single.ready[%0d]", c), dlog_ready[c], (c >= 1 && c <= 4) ? 1 : 0);
    end
    check_val("single.qos", dlog_qos[3], 5);
    check_val("single.id", dlog_id[3], 0);
    check_val("single.grant_cycle", g_cyc(0), 0);

    // QoS priority and its reverse
    reset_phase();
    set_src(0, 1, 4, 15, 100);
    set_src(1, 1, 4, 13, 100);
    repeat (14) run_cycle();
    check_val("qos.first_id", g_id(0), 0);
    check_val("qos.second_id", g_id(1), 1);
    check_val("qos.second_qos", g_qos(1), 13);
    check_val("qos.second_cycle", g_cyc(1), 5);
    reset_phase();
    set_src(0, 1, 4, 13, 100);
    set_src(1, 1, 4, 15, 100);
    repeat (14) run_cycle();
    check_val("qosrev.first_id", g_id(0), 1);
    check_val("qosrev.second_id", g_id(1), 0);
    check_val("qosrev.second_qos", g_qos(1), 13);

    // round-robin alternation at equal priority
    for (int q = 0; q < 2; q++) begin
      reset_phase();
      set_src(0, 4, 1, (q == 0) ? 14 : 0, 100);
      set_src(1, 4, 1, (q == 0) ? 14 : 0, 100);
      repeat (10) run_cycle();
      for (int k = 0; k < 4; k++) begin
        check_val($sformatf("rr%0d.id[%0d]", q, k), g_id(k), k % 2);
        check_val($sformatf("rr%0d.cycle[%0d]", q, k), g_cyc(k), 2 * k);
      end
    end

    // aging promotes the low-priority stream every fourth grant
    reset_phase();
    set_src(0, 20, 1, 0, 100);
    set_src(1, 20, 1, 14, 100);
    repeat (17) run_cycle();
    exp_ids = '{1, 1, 1, 0, 1, 1, 1, 0};
    exp_qs  = '{14, 14, 14, 0, 14, 14, 14, 0};
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("aging.id[%0d]", k), g_id(k), exp_ids[k]);
      check_val($sformatf("aging.qos[%0d]", k), g_qos(k), exp_qs[k]);
    end

    // backpressure while another stream raises a higher QoS
    reset_phase();
    set_src(0, 1, 4, 2, 100);
    run_cycle();
    run_cycle();
    ready_prob = 0;
    set_src(1, 1, 1, 15, 100);
    run_cycle();
    run_cycle();
    ready_prob = 100;
    repeat (6) run_cycle();
    check_val("bp.data_hold2", dlog_data[2], 1);
    check_val("bp.data_hold3", dlog_data[3], 1);
    check_val("bp.ready2", dlog_ready[2], 0);
    check_val("bp.ready3", dlog_ready[3], 0);
    check_val("bp.id_locked", dlog_id[6], 0);
    check_val("bp.last_beat", dlog_last[6], 1);
    check_val("bp.next_id", g_id(1), 1);
    check_val("bp.next_cycle", g_cyc(1), 7);

    // reset in the middle of a packet
    reset_phase();
    set_src(0, 1, 4, 3, 100);
    set_src(1, 1, 4, 3, 100);
    repeat (3) run_cycle();
    rst_req = 1'b1;
    run_cycle();
    rst_req = 1'b0;
    repeat (4) run_cycle();
    check_val("rstmid.valid_before", dlog_valid[3], 1);
    check_val("rstmid.valid_after", dlog_valid[4], 0);
    check_val("rstmid.ready_after", dlog_ready[4], 0);
    check_val("rstmid.qos_after", dlog_qos[4], 0);
    check_val("rstmid.regrant_id", g_id(1), 0);
    check_val("rstmid.regrant_cycle", g_cyc(1), 4);

    // randomized traffic with bubbles, backpressure, QoS churn and resets
    reset_phase();
    for (int i = 0; i < N; i++) set_src(i, 1000000, 0, -1, 75);
    ready_prob = 75;
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        for (int i = 0; i < N; i++) src_prob[i] = 100;
        ready_prob = 100;
      end
      rst_req = ($urandom_range(499) == 0);
      run_cycle();
    end
    rst_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
